lab5_operand_capture: RTL and testbench
=======================================

Name: lab5_operand_capture

Overview:
Upstream stage for the 2-bit magnitude comparator. It debounces the board push-buttons and captures two 2-bit operands, A then B, from SW[1:0] on successive presses of BTNC. It then presents the operands as registered, stable values with a VALID flag. The comparator consumes A/B directly, so its result only changes on a deliberate capture, never on switch bounce.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required before a debounced button level changes (10 ms at 100 MHz). The bench overrides it to 4.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
CLK100MHZ  input  1  system clock, 100 MHz, the block's only clock
CPU_RESETN  input  1  reset, asynchronous, active-low
SW  input  2  operand value from slide switches (asynchronous)
BTNC  input  1  capture button, raw and bouncing, active-high
BTNU  input  1  clear button, raw and bouncing, active-high
A  output  2  captured operand A
B  output  2  captured operand B
VALID  output  1  high when both A and B hold a completed capture
LED  output  2  state indicator: 01 = WAIT_A, 10 = WAIT_B, 11 = READY

Behaviour:
- Reset (CPU_RESETN low, asynchronous assert, synchronous-to-clock deassert):
  - state = WAIT_A; A = 00, B = 00, VALID = 0, LED = 01.
  - All synchronizer flops, debounced levels and counters are cleared to 0.
- Synchronization: SW, BTNC and BTNU each pass through a 2-FF synchronizer. Nothing downstream uses the raw inputs.
- Debounce (applies to BTNC and BTNU independently):
  - The counter resets to 0 whenever the synchronized level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES clocks produces no change.
- Edge detect: a rising edge of a debounced level produces a 1-cycle pulse (cap_p for BTNC, clr_p for BTNU).
  - Holding the button gives exactly one pulse.
  - Release produces no pulse.
- Latency: outputs update DEBOUNCE_CYCLES+4 clocks after raw BTNC/BTNU goes and stays high (2 sync + DEBOUNCE_CYCLES + 1 edge + 1 output register).
- Capture value: the synchronized SW value in the cycle cap_p is high.
- FSM (registered outputs; LED is a direct decode of state):
  - WAIT_A + cap_p: A <= SW_s; go to WAIT_B.
  - WAIT_B + cap_p: B <= SW_s; VALID <= 1; go to READY.
  - READY + cap_p: A <= SW_s; VALID <= 0; B held; go to WAIT_B. This starts a new pair.
  - Any state + clr_p: A <= 00, B <= 00, VALID <= 0; go to WAIT_A.
- Simultaneous cap_p and clr_p: clear wins and the capture is discarded.
- VALID is 0 in WAIT_A and WAIT_B, and 1 only in READY.
- A and B never change except on cap_p, clr_p or reset.
- Reset mid-debounce discards the pending count; no pulse is produced after reset deassertion unless the button is still held for a full DEBOUNCE_CYCLES.
- Unused state encodings recover to WAIT_A on the next clock with outputs cleared.

Decomposition:
- Shared package:
  - state enum (WAIT_A, WAIT_B, READY);
  - LED encoding constants (LED_WAIT_A = 01, LED_WAIT_B = 10, LED_READY = 11);
  - default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES):
  - contents: 2-FF synchronizer, counter, debounced level and rising-edge pulse;
  - ports: clock, reset, raw input, pulse output;
  - instantiated twice, for BTNC and BTNU.
- SW uses only a 2-FF synchronizer in the top level and is not debounced. It is sampled only at the press pulse.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Reset with SW = 11 and all buttons low -> A = 00, B = 00, VALID = 0, LED = 01 immediately on assert, and still so 20 clocks after deassert.
2. SW = 10, BTNC held high 10 clocks -> A = 10 exactly 8 clocks after the BTNC rise, LED = 01 then 10, VALID = 0. Then SW = 01, second press -> B = 01, VALID = 1, LED = 11.
3. BTNC toggling every 2 clocks for 20 clocks, then low -> no capture; A, B, state and VALID unchanged.
4. In READY (A = 10, B = 01), SW = 11, press BTNC -> A = 11, B = 01, VALID = 0, LED = 10.
5. BTNC and BTNU raised on the same clock in WAIT_B -> A = 00, B = 00, VALID = 0, LED = 01; no capture.
6. BTNC held 3 clocks, then CPU_RESETN pulsed low, then BTNC held 10 more clocks -> all outputs at reset values during reset. After release, exactly one capture occurs, 8 clocks after the reset deasserts.

Source files
------------

// File: rtl/lab5_operand_capture_pkg.sv
// lab5_operand_capture_pkg: operand-capture states, LED codes and default debounce length
package lab5_operand_capture_pkg;
   typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, READY = 2'd2} state_t;
   localparam logic [1:0] LED_WAIT_A = 2'b01;
   localparam logic [1:0] LED_WAIT_B = 2'b10;
   localparam logic [1:0] LED_READY  = 2'b11;
   localparam int DEBOUNCE_DEFAULT = 1000000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a raw button, then emits one pulse per press
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] sync;
   logic [CNT_W-1:0] cnt;
   logic level, level_d;
   // pulse is registered so a press lands on the consumer one clock after the level flips
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         sync    <= {sync[0], raw};
         level_d <= level;
         pulse   <= level & ~level_d;
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
         end else cnt <= cnt + CNT_W'(1);
      end
endmodule

// File: rtl/lab5_operand_capture.sv
// lab5_operand_capture: captures operands A then B from SW on debounced BTNC presses, BTNU clears
module lab5_operand_capture
   import lab5_operand_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic [1:0] SW,
   input  logic       BTNC,
   input  logic       BTNU,
   output logic [1:0] A,
   output logic [1:0] B,
   output logic       VALID,
   output logic [1:0] LED
);
   state_t state, state_n;
   logic [1:0] sw_meta, sw_s, a_n, b_n;
   logic valid_n, cap_p, clr_p;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cap (
      .clk(CLK100MHZ), .rst_n(CPU_RESETN), .raw(BTNC), .pulse(cap_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk(CLK100MHZ), .rst_n(CPU_RESETN), .raw(BTNU), .pulse(clr_p));
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         sw_meta <= '0;
         sw_s    <= '0;
         state   <= WAIT_A;
         A       <= '0;
         B       <= '0;
         VALID   <= 1'b0;
      end else begin
         sw_meta <= SW;
         sw_s    <= sw_meta;
         state   <= state_n;
         A       <= a_n;
         B       <= b_n;
         VALID   <= valid_n;
      end
   // clear beats a simultaneous capture; an illegal state encoding is treated like a clear
   always_comb begin
      state_n = state;
      a_n     = A;
      b_n     = B;
      valid_n = VALID;
      if (clr_p || !(state inside {WAIT_A, WAIT_B, READY})) begin
         state_n = WAIT_A;
         a_n     = '0;
         b_n     = '0;
         valid_n = 1'b0;
      end else if (cap_p) begin
         a_n     = (state == WAIT_B) ? A : sw_s;
         b_n     = (state == WAIT_B) ? sw_s : B;
         valid_n = (state == WAIT_B);
         state_n = (state == WAIT_B) ? READY : WAIT_B;
      end
   end
   assign LED = (state == WAIT_B) ? LED_WAIT_B : (state == READY) ? LED_READY : LED_WAIT_A;
endmodule

// File: tb/tb_lab5_operand_capture.sv
// tb_lab5_operand_capture: directed checks of capture, clear, debounce and reset behaviour
module tb_lab5_operand_capture;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [1:0] sw = 2'b11;
   logic btnc = 1'b0;
   logic btnu = 1'b0;
   logic [1:0] a, b, led;
   logic valid;
   int total = 0;
   int bad = 0;

   lab5_operand_capture #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .SW(sw), .BTNC(btnc), .BTNU(btnu),
      .A(a), .B(b), .VALID(valid), .LED(led));

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // exp packs {A, B, VALID, LED}
   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {a, b, valid, led};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed A=%b B=%b VALID=%b LED=%b expected A=%b B=%b VALID=%b LED=%b",
                tag, obs[6:5], obs[4:3], obs[2], obs[1:0], exp[6:5], exp[4:3], exp[2], exp[1:0]);
      end
   endtask

   initial begin
      // 1: reset
      #3 rst_n = 1'b0;
      #1 chk("reset_assert", 7'b00_00_0_01);
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("reset_hold", 7'b00_00_0_01);
      // 2: capture A then B
      sw = 2'b10;
      tick(2);
      btnc = 1'b1;
      tick(7);
      chk("cap_a_early", 7'b00_00_0_01);
      tick(1);
      chk("cap_a", 7'b10_00_0_10);
      tick(2);
      btnc = 1'b0;
      tick(12);
      chk("cap_a_release", 7'b10_00_0_10);
      sw = 2'b01;
      tick(2);
      btnc = 1'b1;
      tick(7);
      chk("cap_b_early", 7'b10_00_0_10);
      tick(1);
      chk("cap_b", 7'b10_01_1_11);
      tick(2);
      btnc = 1'b0;
      tick(12);
      // 3: bounce shorter than the debounce window
      for (int i = 0; i < 5; i++) begin
         btnc = 1'b1;
         tick(2);
         btnc = 1'b0;
         tick(2);
      end
      tick(12);
      chk("glitch", 7'b10_01_1_11);
      // 4: capture from READY starts a new pair
      sw = 2'b11;
      tick(2);
      btnc = 1'b1;
      tick(8);
      chk("ready_recap", 7'b11_01_0_10);
      tick(2);
      btnc = 1'b0;
      tick(12);
      // 5: simultaneous capture and clear in WAIT_B
      btnc = 1'b1;
      btnu = 1'b1;
      tick(7);
      chk("clr_early", 7'b11_01_0_10);
      tick(1);
      chk("clr_wins", 7'b00_00_0_01);
      tick(3);
      chk("clr_hold", 7'b00_00_0_01);
      btnc = 1'b0;
      btnu = 1'b0;
      tick(12);
      // 6: reset in the middle of a debounce
      sw = 2'b10;
      tick(2);
      btnc = 1'b1;
      tick(8);
      chk("pre_reset_cap", 7'b10_00_0_10);
      btnc = 1'b0;
      tick(12);
      sw = 2'b01;
      tick(2);
      btnc = 1'b1;
      tick(3);
      rst_n = 1'b0;
      #1 chk("mid_reset_async", 7'b00_00_0_01);
      tick(2);
      chk("mid_reset_hold", 7'b00_00_0_01);
      rst_n = 1'b1;
      tick(7);
      chk("post_reset_early", 7'b00_00_0_01);
      tick(1);
      chk("post_reset_cap", 7'b01_00_0_10);
      tick(2);
      btnc = 1'b0;
      tick(12);
      chk("post_reset_single", 7'b01_00_0_10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
